// File: rtl/jtdsp16_sio_rx.sv
// -----------------------------------------------------------------------------
// jtdsp16_sio_rx -- DSP16 SIO serial input receiver
//
// Deserialises the serial input pin di into W-bit words. Bits are clocked by
// the external ick pin, and each word is framed by the ild strobe. Completed
// words are moved into the SDX input buffer, and ibf is raised for the
// CPU/interrupt logic. All state advances only when cen is high.
//
// Ports
//   clk       in   1   system clock
//   rst       in   1   asynchronous active-high reset
//   cen       in   1   clock enable (cen2)
//   di        in   1   serial data pin
//   ick       in   1   serial input clock pin (asynchronous to clk)
//   ild       in   1   word-start strobe, sampled together with di
//   sdx_read  in   1   one-cen pulse: CPU reads the input buffer
//   sdx_dout  out  W   input buffer contents
//   ibf       out  1   input buffer full
//   ovf       out  1   sticky overrun flag
//   ovf_clr   in   1   clears ovf (a simultaneous overrun wins)
//
// Configuration
//   JTDSP16_SIORX_LSB_EN  defined: LSB-first shifting (first bit lands in
//                         sdx_dout[0]); undefined: MSB-first.
// -----------------------------------------------------------------------------
module jtdsp16_sio_rx #(
   parameter int SYNC = 2,
   parameter int W    = 16
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         cen,
   input  logic         di,
   input  logic         ick,
   input  logic         ild,
   input  logic         sdx_read,
   output logic [W-1:0] sdx_dout,
   output logic         ibf,
   output logic         ovf,
   input  logic         ovf_clr
);

   localparam int CW = $clog2(W) + 1;
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(W);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LOAD  = 2'd2
   } state_t;

   logic [SYNC-1:0] ick_sync_q;
   logic [SYNC-1:0] ild_sync_q;
   logic [SYNC-1:0] di_sync_q;
   logic            ick_dly_q;

   state_t          state_q;
   logic [W-1:0]    sr_q;
   logic [CW-1:0]   cnt_q;
   logic [W-1:0]    sdx_dout_q;
   logic            ibf_q;
   logic            ovf_q;

   logic [W-1:0]    sr_shift_d;
   logic [CW-1:0]   cnt_inc_d;
   logic [W-1:0]    sdx_dout_d;
   logic            ibf_d;
   logic            ovf_d;

   logic            ick_s;
   logic            ild_s;
   logic            di_s;
   logic            bit_ev;

   // di and ild travel through the same depth as ick, so they line up with the edge
   assign ick_s    = ick_sync_q[SYNC-1];
   assign ild_s    = ild_sync_q[SYNC-1];
   assign di_s     = di_sync_q[SYNC-1];

   assign sdx_dout = sdx_dout_q;
   assign ibf      = ibf_q;
   assign ovf      = ovf_q;

   // Synchroniser chains for the asynchronous serial pins, plus the ick edge delay
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ick_sync_q <= {SYNC{1'b0}};
         ild_sync_q <= {SYNC{1'b0}};
         di_sync_q  <= {SYNC{1'b0}};
         ick_dly_q  <= 1'b0;
      end else if (cen) begin
         ick_sync_q <= {ick_sync_q[SYNC-2:0], ick};
         ild_sync_q <= {ild_sync_q[SYNC-2:0], ild};
         di_sync_q  <= {di_sync_q[SYNC-2:0], di};
         ick_dly_q  <= ick_s;
      end
   end

   // Bit-event detection, shift/count next values and buffer/flag next values
   always_comb begin
      bit_ev     = ick_s & ~ick_dly_q;
`ifdef JTDSP16_SIORX_LSB_EN
      sr_shift_d = {di_s, sr_q[W-1:1]};
`else
      sr_shift_d = {sr_q[W-2:0], di_s};
`endif
      cnt_inc_d  = cnt_q + CNT_ONE;
      sdx_dout_d = sdx_dout_q;
      ibf_d      = ibf_q;
      ovf_d      = ovf_q & ~ovf_clr;
      if (state_q == ST_LOAD) begin
         if (!ibf_q) begin
            sdx_dout_d = sr_q;
            ibf_d      = 1'b1;
         end else if (sdx_read) begin
            // The read retires the old word; the new one takes its place, ibf stays set
            sdx_dout_d = sr_q;
         end else begin
            // Buffer still full and unread: drop the new word. The set overrides ovf_clr
            ovf_d      = 1'b1;
         end
      end else if (sdx_read) begin
         ibf_d = 1'b0;
      end else begin
         ibf_d = ibf_q;
      end
   end

   // Word-framing FSM, shift register, and registered buffer/flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         sr_q       <= {W{1'b0}};
         cnt_q      <= CNT_ZERO;
         sdx_dout_q <= {W{1'b0}};
         ibf_q      <= 1'b0;
         ovf_q      <= 1'b0;
      end else if (cen) begin
         sdx_dout_q <= sdx_dout_d;
         ibf_q      <= ibf_d;
         ovf_q      <= ovf_d;
         case (state_q)
            // LOAD also accepts a new start bit, so back-to-back words are legal
            ST_IDLE, ST_LOAD: begin
               if (bit_ev && ild_s) begin
                  sr_q    <= sr_shift_d;
                  cnt_q   <= CNT_ONE;
                  state_q <= ST_SHIFT;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               if (bit_ev) begin
                  sr_q <= sr_shift_d;
                  if (ild_s) begin
                     // A new strobe mid-word restarts framing. Older bits shift out before the word completes
                     cnt_q <= CNT_ONE;
                  end else begin
                     cnt_q <= cnt_inc_d;
                     if (cnt_inc_d == CNT_FULL) begin
                        state_q <= ST_LOAD;
                     end else begin
                        state_q <= ST_SHIFT;
                     end
                  end
               end else begin
                  state_q <= ST_SHIFT;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jtdsp16_sio_rx.sv
// -----------------------------------------------------------------------------
// tb_jtdsp16_sio_rx -- self-checking bench for jtdsp16_sio_rx
//
// The reference model tracks each frame as a list of received bits. It builds
// a word arithmetically once W bits are collected, then applies the
// buffer/flag rules at word level.
// -----------------------------------------------------------------------------
module tb_jtdsp16_sio_rx;

   localparam int SYNC = 2;
   localparam int W    = 16;

   logic         clk      = 1'b0;
   logic         rst      = 1'b1;
   logic         cen      = 1'b0;
   logic         di       = 1'b0;
   logic         ick      = 1'b0;
   logic         ild      = 1'b0;
   logic         sdx_read = 1'b0;
   logic         ovf_clr  = 1'b0;
   logic [W-1:0] sdx_dout;
   logic         ibf;
   logic         ovf;

   int n_chk    = 0;
   int n_pass   = 0;
   int max_idle = 0;

   // reference model state
   bit           fr[$];
   bit           m_in;
   logic [W-1:0] m_dout;
   bit           m_ibf;
   bit           m_ovf;

   always #5 clk = ~clk;

   jtdsp16_sio_rx #(.SYNC(SYNC), .W(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .cen      (cen),
      .di       (di),
      .ick      (ick),
      .ild      (ild),
      .sdx_read (sdx_read),
      .sdx_dout (sdx_dout),
      .ibf      (ibf),
      .ovf      (ovf),
      .ovf_clr  (ovf_clr)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic void m_reset();
      fr.delete();
      m_in   = 1'b0;
      m_dout = '0;
      m_ibf  = 1'b0;
      m_ovf  = 1'b0;
   endfunction

   // One received bit; rd/clr describe pulses present when the word would be transferred
   function automatic void m_bit(input bit b, input bit l, input bit rd, input bit clr);
      int unsigned w;
      bit          ov;
      if (l) begin
         fr.delete();
         m_in = 1'b1;
      end
      if (m_in) fr.push_back(b);
      if (m_in && fr.size() == W) begin
         w = 0;
         for (int i = 0; i < W; i++) begin
`ifdef JTDSP16_SIORX_LSB_EN
            w = w | (32'(fr[i]) << i);
`else
            w = w | (32'(fr[i]) << (W - 1 - i));
`endif
         end
         ov = m_ibf && !rd;
         if (!m_ibf) begin
            m_dout = w[W-1:0];
            m_ibf  = 1'b1;
         end else if (rd) begin
            m_dout = w[W-1:0];
         end
         if (ov) m_ovf = 1'b1;
         else if (clr) m_ovf = 1'b0;
         fr.delete();
         m_in = 1'b0;
      end
   endfunction

   // n cen-enabled clock edges, each preceded by random cen=0 cycles that must hold outputs
   task automatic step(input int n);
      int          idle;
      logic [31:0] snap;
      for (int i = 0; i < n; i++) begin
         idle = int'($urandom_range(0, max_idle));
         for (int k = 0; k < idle; k++) begin
            cen  = 1'b0;
            snap = {14'd0, sdx_dout, ibf, ovf};
            @(posedge clk); #1;
            chk("cen0_hold", {14'd0, sdx_dout, ibf, ovf}, snap);
         end
         cen = 1'b1;
         @(posedge clk); #1;
      end
      cen = 1'b0;
   endtask

   task automatic send_bit(input bit b, input bit l);
      di  = b;
      ild = l;
      step(2);
      ick = 1'b1;
      m_bit(b, l, 1'b0, 1'b0);
      step(2);
      ick = 1'b0;
   endtask

   // Word goes out MSB of w first on the wire, ild on the first bit
   task automatic send_word(input logic [W-1:0] w);
      for (int i = W - 1; i >= 0; i--) send_bit(w[i], i == W - 1);
   endtask

   // Like send_word, but times the last bit: checks ibf latency, pulses rd/clr in the transfer cycle
   task automatic send_word_timed(input logic [W-1:0] w, input bit rd, input bit clr);
      bit           pre_ibf;
      logic [W-1:0] pre_dout;
      for (int i = W - 1; i >= 1; i--) send_bit(w[i], i == W - 1);
      pre_ibf  = m_ibf;
      pre_dout = m_dout;
      di  = w[0];
      ild = 1'b0;
      step(2);
      ick = 1'b1;
      m_bit(w[0], 1'b0, rd, clr);
      for (int i = 0; i < SYNC + 1; i++) begin
         step(1);
         chk("lat_ibf_early", 32'(ibf), 32'(pre_ibf));
         chk("lat_dout_early", 32'(sdx_dout), 32'(pre_dout));
      end
      sdx_read = rd;
      ovf_clr  = clr;
      step(1);
      sdx_read = 1'b0;
      ovf_clr  = 1'b0;
      chk("lat_ibf", 32'(ibf), 32'(m_ibf));
      chk("lat_dout", 32'(sdx_dout), 32'(m_dout));
      ick = 1'b0;
   endtask

   task automatic settle_check(input string tag);
      step(SYNC + 3);
      chk({tag, "_dout"}, 32'(sdx_dout), 32'(m_dout));
      chk({tag, "_ibf"}, 32'(ibf), 32'(m_ibf));
      chk({tag, "_ovf"}, 32'(ovf), 32'(m_ovf));
   endtask

   task automatic do_read();
      sdx_read = 1'b1;
      step(1);
      sdx_read = 1'b0;
      m_ibf = 1'b0;
   endtask

   task automatic do_clr();
      ovf_clr = 1'b1;
      step(1);
      ovf_clr = 1'b0;
      m_ovf = 1'b0;
   endtask

   initial begin
      logic [W-1:0] rw;
      int           op;
      int           k;

      m_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_dout", 32'(sdx_dout), 32'h0);
      chk("rst_ibf", 32'(ibf), 32'h0);
      chk("rst_ovf", 32'(ovf), 32'h0);

      // Single word with latency check, then a read
      send_word_timed(16'hA5C3, 1'b0, 1'b0);
      settle_check("t2");
`ifdef JTDSP16_SIORX_LSB_EN
      chk("t2_const", 32'(sdx_dout), 32'h0000C3A5);
`else
      chk("t2_const", 32'(sdx_dout), 32'h0000A5C3);
`endif
      do_read();
      settle_check("t2_read");

      // Overrun, clear, then overrun coinciding with ovf_clr
      send_word(16'h1234);
      send_word(16'hBEEF);
      settle_check("t3");
      do_clr();
      settle_check("t3_clr");
      send_word_timed(16'h4321, 1'b0, 1'b1);
      settle_check("t3_setwins");
      do_read();
      do_clr();

      // Read pulsed in the transfer cycle of the second word
      send_word(16'h1234);
      send_word_timed(16'h5678, 1'b1, 1'b0);
      settle_check("t4");
      do_read();

      // Partial word aborted by a fresh ild
      for (int i = 0; i < 7; i++) send_bit(1'b1, i == 0);
      send_word(16'h0F0F);
      settle_check("t5");
      do_read();

      // Bit stream 1,0,0,...: bit-order check
      send_word(16'h8000);
      settle_check("t6");
`ifdef JTDSP16_SIORX_LSB_EN
      chk("t6_const", 32'(sdx_dout), 32'h00000001);
`else
      chk("t6_const", 32'(sdx_dout), 32'h00008000);
`endif

      // Async reset mid-word, then bits without ild must be ignored
      send_word(16'hFFFF);
      send_word(16'h0001);
      for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0);
      #2 rst = 1'b1;
      #1;
      chk("t1_async_dout", 32'(sdx_dout), 32'h0);
      chk("t1_async_ibf", 32'(ibf), 32'h0);
      chk("t1_async_ovf", 32'(ovf), 32'h0);
      m_reset();
      step(2);
      rst = 1'b0;
      for (int i = 0; i < W + 11; i++) send_bit(1'b1, 1'b0);
      settle_check("t1_noild");

      // Randomised traffic with random cen gaps
      max_idle = 2;
      for (int it = 0; it < 40; it++) begin
         op = int'($urandom_range(0, 4));
         case (op)
            0, 1: begin
               rw = W'($urandom);
               if ($urandom_range(0, 1) == 1) begin
                  k = int'($urandom_range(1, W - 1));
                  for (int i = 0; i < k; i++) send_bit(1'($urandom), i == 0);
               end
               send_word(rw);
            end
            2: do_read();
            3: do_clr();
            default: begin
               for (int i = 0; i < 5; i++) send_bit(1'($urandom), 1'b0);
            end
         endcase
         settle_check("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
